seg_decode8: RTL and testbench

SEG_DECODE8 -- requirements
Module: seg_decode8

---
 rtl/seg_decode8.sv | 155 +++++++++++++++
 tb/tb_seg_decode8.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg_decode8.sv
// seg_decode8: sequential decoder from common-anode 8-segment codes to hex nibbles.
// One digit per cycle goes through a single shared decoder. The result is handed
// to the consumer with a valid/ready handshake.
// Optional feature: define SEG_DP_CAPTURE_EN to add the oDp decimal-point port.
module seg_decode8 #(
    parameter int unsigned DIGITS     = 8,
    parameter logic [3:0]  ERR_NIBBLE = 4'h0
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [63:0] iHex,
    input  logic        iValid,
    output logic        oReady,
    output logic [31:0] oNum,
    output logic [7:0]  oErr,
    output logic        oValid,
    input  logic        iReady
`ifdef SEG_DP_CAPTURE_EN
    ,
    output logic [7:0]  oDp
`endif
);

    localparam int unsigned HEX_W = 64;
    localparam int unsigned NUM_W = 32;
    localparam int unsigned DIG_W = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned BYTE_W = 8;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        DONE   = 2'd2
    } stateT;

    stateT              state;
    stateT              stateNext;
    logic [HEX_W-1:0]   hexReg;
    logic [HEX_W-1:0]   hexNext;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idxNext;
    logic [NUM_W-1:0]   numNext;
    logic [DIG_W-1:0]   errNext;
    logic [BYTE_W-1:0]  curByte;
    logic [NIB_W-1:0]   decNib;
    logic               decBad;
`ifdef SEG_DP_CAPTURE_EN
    logic [DIG_W-1:0]   dpNext;
`else
    logic               unusedDpBit;
    assign unusedDpBit = curByte[BYTE_W-1];
`endif

    assign curByte = hexReg[{idx, 3'b000} +: BYTE_W];

    // Shared decoder: segment pattern (bits 6:0) to nibble, flag anything unknown.
    always_comb begin
        decNib = ERR_NIBBLE;
        decBad = 1'b0;
        case (curByte[6:0])
            7'h40: decNib = 4'h0;
            7'h79: decNib = 4'h1;
            7'h24: decNib = 4'h2;
            7'h30: decNib = 4'h3;
            7'h19: decNib = 4'h4;
            7'h12: decNib = 4'h5;
            7'h02: decNib = 4'h6;
            7'h78: decNib = 4'h7;
            7'h00: decNib = 4'h8;
            7'h10: decNib = 4'h9;
            7'h08: decNib = 4'hA;
            7'h03: decNib = 4'hB;
            7'h27: decNib = 4'hC;
            7'h21: decNib = 4'hD;
            7'h06: decNib = 4'hE;
            7'h0E: decNib = 4'hF;
            default: decBad = 1'b1;
        endcase
    end

    // Next-state and datapath update: capture, walk the digits, hold until taken.
    always_comb begin
        stateNext = state;
        hexNext   = hexReg;
        idxNext   = idx;
        numNext   = oNum;
        errNext   = oErr;
`ifdef SEG_DP_CAPTURE_EN
        dpNext    = oDp;
`endif
        case (state)
            IDLE: begin
                if (iValid) begin
                    hexNext   = iHex;
                    idxNext   = '0;
                    numNext   = '0;
                    errNext   = '0;
`ifdef SEG_DP_CAPTURE_EN
                    dpNext    = '0;
`endif
                    stateNext = DECODE;
                end
            end
            DECODE: begin
                numNext[{idx, 2'b00} +: NIB_W] = decNib;
                errNext[idx] = decBad;
`ifdef SEG_DP_CAPTURE_EN
                dpNext[idx]  = ~curByte[BYTE_W-1];
`endif
                if (idx == LAST_IDX) begin
                    stateNext = DONE;
                end else begin
                    idxNext = idx + IDX_W'(1);
                end
            end
            DONE: begin
                if (iReady) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State and result registers; handshake flags follow the next state.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state  <= IDLE;
            hexReg <= '0;
            idx    <= '0;
            oNum   <= '0;
            oErr   <= '0;
            oReady <= 1'b1;
            oValid <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
            oDp    <= '0;
`endif
        end else begin
            state  <= stateNext;
            hexReg <= hexNext;
            idx    <= idxNext;
            oNum   <= numNext;
            oErr   <= errNext;
            oReady <= (stateNext == IDLE);
            oValid <= (stateNext == DONE);
`ifdef SEG_DP_CAPTURE_EN
            oDp    <= dpNext;
`endif
        end
    end

endmodule

// File: tb/tb_seg_decode8.sv
// Bench for seg_decode8: directed vectors plus random codes against a table-search model.
module tb_seg_decode8;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] hexA, hexB;
    logic        validInA, validInB;
    logic        readyA, readyB;
    logic [31:0] numA, numB;
    logic [7:0]  errA, errB;
    logic        validA, validB;
    logic        readyInA, readyInB;
`ifdef SEG_DP_CAPTURE_EN
    logic [7:0]  dpA, dpB;
`endif

    int nChecks = 0;
    int nPass   = 0;

    // Segment pattern for each hex value, index = value.
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    seg_decode8 dutA (
        .iClk(clk), .iRst(rst), .iHex(hexA), .iValid(validInA), .oReady(readyA),
        .oNum(numA), .oErr(errA), .oValid(validA), .iReady(readyInA)
`ifdef SEG_DP_CAPTURE_EN
        , .oDp(dpA)
`endif
    );

    seg_decode8 #(.DIGITS(4), .ERR_NIBBLE(4'hE)) dutB (
        .iClk(clk), .iRst(rst), .iHex(hexB), .iValid(validInB), .oReady(readyB),
        .oNum(numB), .oErr(errB), .oValid(validB), .iReady(readyInB)
`ifdef SEG_DP_CAPTURE_EN
        , .oDp(dpB)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: search the pattern table for each active digit.
    function automatic void refModel(input logic [63:0] hex, input int digits, input logic [3:0] errNib,
                                     output logic [31:0] num, output logic [7:0] err, output logic [7:0] dp);
        logic [7:0] b;
        bit found;
        num = '0; err = '0; dp = '0;
        for (int k = 0; k < digits; k++) begin
            b = hex[8*k +: 8];
            found = 1'b0;
            for (int v = 0; v < 16; v++) begin
                if (b[6:0] == SEG[v]) begin
                    num[4*k +: 4] = 4'(v);
                    found = 1'b1;
                end
            end
            if (!found) begin
                num[4*k +: 4] = errNib;
                err[k] = 1'b1;
            end
            dp[k] = ~b[7];
        end
    endfunction

    function automatic logic [63:0] randHex();
        logic [63:0] h;
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) != 0)
                h[8*k +: 8] = {1'($urandom_range(0, 1)), SEG[$urandom_range(0, 15)]};
            else
                h[8*k +: 8] = 8'($urandom);
        end
        return h;
    endfunction

    // One full transaction on dutA with backpressure of `hold` cycles.
    task automatic runA(input logic [63:0] hex, input logic [31:0] expNum, input logic [7:0] expErr,
                        input logic [7:0] expDp, input int hold);
        int lat;
        bit stable;
        logic [31:0] snapNum;
        logic [7:0]  snapErr;
        check("idleReady", {validA, readyA}, 2'b01);
        hexA = hex; validInA = 1'b1;
        @(negedge clk);
        validInA = 1'b0;
        hexA = {$urandom, $urandom};
        check("busy", {validA, readyA}, 2'b00);
        lat = 0;
        while (!validA && lat < 20) begin
            @(negedge clk);
            lat++;
            hexA = {$urandom, $urandom};
        end
        check("latency", 64'(lat), 64'd8);
        check("num", numA, expNum);
        check("err", errA, expErr);
`ifdef SEG_DP_CAPTURE_EN
        check("dp", dpA, expDp);
`else
        if (expDp != expDp) $display("unreachable");
`endif
        snapNum = numA; snapErr = errA; stable = 1'b1;
        for (int c = 0; c < hold; c++) begin
            validInA = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!(validA && !readyA && numA == snapNum && errA == snapErr)) stable = 1'b0;
        end
        check("holdStable", 64'(stable), 64'd1);
        readyInA = 1'b1; validInA = 1'b1;
        @(negedge clk);
        readyInA = 1'b0;
        check("release", {validA, readyA}, 2'b01);
        validInA = 1'b0;
        @(negedge clk);
    endtask

    // One transaction on dutB (4 digits, consumer always ready).
    task automatic runB(input logic [63:0] hex, input logic [31:0] expNum, input logic [7:0] expErr);
        int lat;
        check("idleReadyB", {validB, readyB}, 2'b01);
        hexB = hex; validInB = 1'b1;
        @(negedge clk);
        validInB = 1'b0;
        hexB = {$urandom, $urandom};
        lat = 0;
        while (!validB && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latencyB", 64'(lat), 64'd4);
        check("numB", numB, expNum);
        check("errB", errB, expErr);
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] h;
        logic [31:0] n;
        logic [7:0]  e, d;
        bit sawValid;
        rst = 1'b1; hexA = '0; hexB = '0;
        validInA = 1'b0; validInB = 1'b0; readyInA = 1'b0; readyInB = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rstA", {validA, readyA, numA, errA}, {2'b01, 32'h0, 8'h0});
        check("rstB", {validB, readyB, numB, errB}, {2'b01, 32'h0, 8'h0});

        runA(64'hF9A4B099_9282F880, 32'h12345678, 8'h00, 8'h00, 5);
        runA(64'hF9A4B099_FF82F880, 32'h12340678, 8'h08, 8'h00, 0);
`ifdef SEG_DP_CAPTURE_EN
        runA(64'hF9A4B099_9282F800, 32'h12345678, 8'h00, 8'h01, 1);
`endif
        for (int t = 0; t < 25; t++) begin
            h = randHex();
            refModel(h, 8, 4'h0, n, e, d);
            runA(h, n, e, d, $urandom_range(0, 4));
        end

        // Reset in the fourth decode cycle must abort with no result.
        hexA = 64'hF9A4B099_9282F880; validInA = 1'b1;
        @(negedge clk);
        validInA = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midRst", {validA, readyA, numA, errA}, {2'b01, 32'h0, 8'h0});
        sawValid = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (validA) sawValid = 1'b1;
        end
        check("noValidAfterRst", 64'(sawValid), 64'd0);

        runB(64'h0000_0000_F9A4B099, 32'h00001234, 8'h00);
        for (int t = 0; t < 15; t++) begin
            h = randHex();
            refModel(h, 4, 4'hE, n, e, d);
            runB(h, n, e);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
